// File: rtl/hello_merger.sv
// hello_merger: packet-atomic 2:1 merge of SRIO HELLO AXI-Stream sources into one registered output,
// flagging SWRITE-port packets whose first-beat FTYPE is not 6.
module hello_merger #(
  parameter int DW = 64,
  parameter int UW = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESET,
  input  logic          S0_AXIS_TVALID,
  output logic          S0_AXIS_TREADY,
  input  logic [DW-1:0] S0_AXIS_TDATA,
  input  logic          S0_AXIS_TLAST,
  input  logic [UW-1:0] S0_AXIS_TUSER,
  input  logic          S1_AXIS_TVALID,
  output logic          S1_AXIS_TREADY,
  input  logic [DW-1:0] S1_AXIS_TDATA,
  input  logic          S1_AXIS_TLAST,
  input  logic [UW-1:0] S1_AXIS_TUSER,
  output logic          M_AXIS_TVALID,
  input  logic          M_AXIS_TREADY,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic          M_AXIS_TLAST,
  output logic [UW-1:0] M_AXIS_TUSER,
  output logic          M_AXIS_TSRC,
  output logic          ftype_err
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state_q, state_d;
  logic out_full_q, last_grant_q, first_beat_q, ftype_err_q, tlast_q, tsrc_q;
  logic [DW-1:0] tdata_q;
  logic [UW-1:0] tuser_q;
  logic rdy, acc, sel1, pick1;
  always_comb begin
    rdy = ~out_full_q | M_AXIS_TREADY;
    sel1 = state_q == GNT1;
    S0_AXIS_TREADY = (state_q == GNT0) & rdy;
    S1_AXIS_TREADY = sel1 & rdy;
    acc = (S0_AXIS_TREADY & S0_AXIS_TVALID) | (S1_AXIS_TREADY & S1_AXIS_TVALID);
    // on a tie, round-robin hands the grant to whoever did not win last
    pick1 = (S0_AXIS_TVALID & S1_AXIS_TVALID) ? (~FIXED_PRIO & ~last_grant_q) : S1_AXIS_TVALID;
    state_d = (state_q == IDLE) ? ((S0_AXIS_TVALID | S1_AXIS_TVALID) ? (pick1 ? GNT1 : GNT0) : IDLE)
                                : ((acc & (sel1 ? S1_AXIS_TLAST : S0_AXIS_TLAST)) ? IDLE : state_q);
  end
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state_q      <= IDLE;
      out_full_q   <= 1'b0;
      last_grant_q <= 1'b1;
      first_beat_q <= 1'b1;
      ftype_err_q  <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= '0;
      tlast_q      <= 1'b0;
      tsrc_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d != IDLE) last_grant_q <= state_d == GNT1;
      out_full_q   <= acc | (out_full_q & ~M_AXIS_TREADY);
      first_beat_q <= (state_q == IDLE) | (first_beat_q & ~acc);
      ftype_err_q  <= acc & sel1 & first_beat_q & (S1_AXIS_TDATA[55:52] != 4'h6);
      if (acc) begin
        tdata_q <= sel1 ? S1_AXIS_TDATA : S0_AXIS_TDATA;
        tuser_q <= sel1 ? S1_AXIS_TUSER : S0_AXIS_TUSER;
        tlast_q <= sel1 ? S1_AXIS_TLAST : S0_AXIS_TLAST;
        tsrc_q  <= sel1;
      end
    end
  end
  assign M_AXIS_TVALID = out_full_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TUSER  = tuser_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TSRC   = tsrc_q;
  assign ftype_err     = ftype_err_q;
endmodule

// File: tb/tb_hello_merger.sv
// tb_hello_merger: random two-source packet traffic against a cycle-level reference of the merge rules,
// plus a fixed-priority instance that must starve S1 while S0 keeps requesting.
module tb_hello_merger;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        bv [2];
  logic [63:0] bd [2];
  logic [31:0] bu [2];
  logic        bl [2];
  int          blen [2];
  int          bidx [2];
  logic        s0_r, s1_r, m_v, m_l, m_s, ferr;
  logic        m_r = 1'b0;
  logic [63:0] m_d;
  logic [31:0] m_u;
  int tests = 0;
  int fails = 0;
  hello_merger #(.DW(64), .UW(32), .FIXED_PRIO(1'b0)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .S0_AXIS_TVALID(bv[0]), .S0_AXIS_TREADY(s0_r), .S0_AXIS_TDATA(bd[0]), .S0_AXIS_TLAST(bl[0]), .S0_AXIS_TUSER(bu[0]),
    .S1_AXIS_TVALID(bv[1]), .S1_AXIS_TREADY(s1_r), .S1_AXIS_TDATA(bd[1]), .S1_AXIS_TLAST(bl[1]), .S1_AXIS_TUSER(bu[1]),
    .M_AXIS_TVALID(m_v), .M_AXIS_TREADY(m_r), .M_AXIS_TDATA(m_d), .M_AXIS_TLAST(m_l), .M_AXIS_TUSER(m_u),
    .M_AXIS_TSRC(m_s), .ftype_err(ferr)
  );
  logic        p_rst = 1'b1;
  logic        p_v0 = 1'b0;
  logic        p_v1 = 1'b0;
  logic        p_r0, p_r1, p_mv, p_ml, p_ms, p_err;
  logic [63:0] p_d = 64'h0060_0000_0000_0001;
  logic [63:0] p_md;
  logic [31:0] p_u = 32'h0;
  logic [31:0] p_mu;
  logic        p_one = 1'b1;
  logic        p_done = 1'b0;
  hello_merger #(.DW(64), .UW(32), .FIXED_PRIO(1'b1)) dut_fp (
    .AXIS_ACLK(clk), .AXIS_ARESET(p_rst),
    .S0_AXIS_TVALID(p_v0), .S0_AXIS_TREADY(p_r0), .S0_AXIS_TDATA(p_d), .S0_AXIS_TLAST(p_one), .S0_AXIS_TUSER(p_u),
    .S1_AXIS_TVALID(p_v1), .S1_AXIS_TREADY(p_r1), .S1_AXIS_TDATA(p_d), .S1_AXIS_TLAST(p_one), .S1_AXIS_TUSER(p_u),
    .M_AXIS_TVALID(p_mv), .M_AXIS_TREADY(p_one), .M_AXIS_TDATA(p_md), .M_AXIS_TLAST(p_ml), .M_AXIS_TUSER(p_mu),
    .M_AXIS_TSRC(p_ms), .ftype_err(p_err)
  );
  logic        m_idle, m_gnt, m_lastg, m_full, m_first, m_err, e_l, e_s;
  logic [63:0] e_d;
  logic [31:0] e_u;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic mdl_reset();
    m_idle = 1'b1; m_gnt = 1'b0; m_lastg = 1'b1; m_full = 1'b0; m_first = 1'b1; m_err = 1'b0;
    e_d = '0; e_u = '0; e_l = 1'b0; e_s = 1'b0;
  endtask
  task automatic gen_beat(input int i);
    logic [63:0] d;
    d = {$urandom, $urandom};
    if (bidx[i] == 0) d[55:52] = (i == 1 && $urandom_range(0, 1) == 1) ? 4'h6 : 4'($urandom_range(0, 15));
    bd[i] = d;
    bu[i] = $urandom;
    bl[i] = bidx[i] == blen[i] - 1;
  endtask
  task automatic new_pkt(input int i);
    blen[i] = $urandom_range(1, 4);
    bidx[i] = 0;
    gen_beat(i);
  endtask
  initial begin
    logic er0, er1, a0, a1, acc;
    for (int i = 0; i < 2; i++) begin
      blen[i] = 2; bidx[i] = 0; gen_beat(i); bv[i] = 1'b0;
    end
    mdl_reset();
    @(posedge clk); #1;
    rst = 1'b0; m_r = 1'b1; bv[0] = 1'b1; bv[1] = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      er0 = !m_idle && !m_gnt && (!m_full || m_r);
      er1 = !m_idle && m_gnt && (!m_full || m_r);
      check("s0_tready", s0_r, er0);
      check("s1_tready", s1_r, er1);
      check("m_tvalid", m_v, m_full);
      check("m_tdata", m_d, e_d);
      check("m_tuser", m_u, e_u);
      check("m_tlast", m_l, e_l);
      check("m_tsrc", m_s, e_s);
      check("ftype_err", ferr, m_err);
      a0 = er0 && bv[0];
      a1 = er1 && bv[1];
      acc = a0 || a1;
      if (rst) mdl_reset();
      else begin
        m_err = a1 && m_first && bd[1][55:52] != 4'h6;
        if (acc) begin
          e_d = bd[m_gnt]; e_u = bu[m_gnt]; e_l = bl[m_gnt]; e_s = m_gnt; m_full = 1'b1;
        end else if (m_full && m_r) m_full = 1'b0;
        m_first = m_idle || (m_first && !acc);
        if (m_idle) begin
          if (bv[0] || bv[1]) begin
            m_gnt = (bv[0] && bv[1]) ? !m_lastg : bv[1];
            m_lastg = m_gnt;
            m_idle = 1'b0;
          end
        end else if (acc && bl[m_gnt]) m_idle = 1'b1;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          new_pkt(i); bv[i] = 1'b0;
        end else if (i == 0 ? a0 : a1) begin
          if (bl[i]) begin
            new_pkt(i); bv[i] = ($urandom_range(0, 1) == 1);
          end else begin
            bidx[i]++; gen_beat(i); bv[i] = ($urandom_range(0, 3) != 0);
          end
        end else if (!bv[i]) bv[i] = ($urandom_range(0, 2) != 0);
      end
      m_r = (cyc < 200) ? 1'b1 : ($urandom_range(0, 9) < 7);
      rst = (cyc > 5) && ($urandom_range(0, 249) == 0);
    end
    for (int k = 0; k < 1000 && !p_done; k++) @(posedge clk);
    check("fp_done", p_done, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    int cnt;
    logic s1_seen, got;
    cnt = 0; s1_seen = 1'b0; got = 1'b0;
    p_v0 = 1'b1; p_v1 = 1'b1;
    @(posedge clk); #1;
    p_rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (p_r1) s1_seen = 1'b1;
      if (p_r0) cnt++;
    end
    check("fp_s0_grants", cnt, 20);
    check("fp_s1_starved", s1_seen, 1'b0);
    @(posedge clk); #1;
    p_v0 = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      got = p_r1;
    end
    check("fp_s1_grant", got, 1'b1);
    p_done = 1'b1;
  end
endmodule

// File: doc/hello_merger.md
Name: hello_merger

Overview:
- Transmit-side counterpart of the HELLO FTYPE router: merges two AXI-Stream SRIO HELLO packet streams (S0 = general/non-SWRITE, S1 = SWRITE) into one stream toward the SRIO core.
- Arbitration is packet-atomic; a granted source keeps the output until its TLAST beat is accepted.
- Output is a one-entry registered stage; a first-beat FTYPE sanity check flags SWRITE-port packets that are not FTYPE 6.

Parameters:
- DW, 64, TDATA width; HELLO header FTYPE is TDATA[55:52] of the first beat.
- UW, 32, TUSER width.
- FIXED_PRIO, 0: 0 = round-robin between S0/S1; 1 = S0 always wins when both are pending.

Ports:
- AXIS_ACLK  in  1  clock.
- AXIS_ARESET  in  1  reset; one clock; reset is synchronous and active-high.
- S0_AXIS_TVALID  in  1  general-stream valid.
- S0_AXIS_TREADY  out  1  general-stream ready.
- S0_AXIS_TDATA  in  DW  general-stream data.
- S0_AXIS_TLAST  in  1  general-stream end of packet.
- S0_AXIS_TUSER  in  UW  general-stream user (src/dest IDs).
- S1_AXIS_TVALID / TREADY / TDATA / TLAST / TUSER  same as S0, SWRITE stream.
- M_AXIS_TVALID  out  1  merged valid.
- M_AXIS_TREADY  in  1  merged ready.
- M_AXIS_TDATA  out  DW  merged data.
- M_AXIS_TLAST  out  1  merged end of packet.
- M_AXIS_TUSER  out  UW  merged user.
- M_AXIS_TSRC  out  1  source of the current beat: 0 = S0, 1 = S1.
- ftype_err  out  1  one-cycle pulse, S1 first beat with FTYPE != 4'h6.

Behaviour:
- Reset: state IDLE, out_full=0, last_grant=1 (so S0 wins the first tie), first_beat=1. M_AXIS_TVALID=0; TDATA/TUSER/TLAST/TSRC=0; ftype_err=0; S0/S1 TREADY=0.
- Arbiter states:
  - IDLE: both TREADY=0. If any TVALID: go to GNT0 or GNT1 next cycle. Single requester gets the grant. On a tie, FIXED_PRIO=1 picks S0; otherwise the grant goes opposite last_grant. last_grant updates on entry to GNT0/GNT1.
  - GNT0/GNT1: only the granted TREADY may be high; TREADY_x = ~out_full | M_AXIS_TREADY. On a granted beat accepted with TLAST=1, go to IDLE next cycle.
  - One idle bubble between packets is required; no back-to-back grant without passing through IDLE.
- Output stage:
  - On an accepted input beat, register TDATA/TLAST/TUSER, set TSRC to the grant and set out_full.
  - On a master transfer with no new accept, clear out_full. A simultaneous master transfer and accept keeps out_full=1 and loads the new beat.
  - M_AXIS_TVALID = out_full. Latency is 1 cycle input to output.
  - Full throughput within a packet when M_AXIS_TREADY stays high.
  - Output registers hold while M_AXIS_TVALID=1 and TREADY=0.
- first_beat: set in IDLE, cleared after the first accepted beat of a grant.
  - ftype_err pulses the cycle after an accepted S1 first beat with TDATA[55:52] != 6.
  - The packet is still forwarded unchanged.
  - No check is made on S0.
- An input TVALID dropping mid-packet: the grant is held and the arbiter waits. No timeout.
- TLAST on a single-beat packet is legal: accept, then IDLE.
- Reset mid-packet: everything returns to reset values next cycle; a partially sent packet is abandoned (downstream sees no TLAST).
- Non-granted source is never accepted, even if valid, including in the TLAST cycle.

Test Plan:
- Single S0 packet, 3 beats, header TDATA=64'h00A0_0000_0000_0001, M_AXIS_TREADY=1 -> S0_TREADY rises 1 cycle after TVALID; output beats appear 1 cycle after accept with TSRC=0; TLAST on beat 3; state returns to IDLE.
- S0 and S1 both valid with 2-beat packets each, FIXED_PRIO=0, from reset -> S0 packet first, then S1; next tie grants S0 again. With FIXED_PRIO=1, S0 wins every tie.
- Backpressure: S1 4-beat packet, M_AXIS_TREADY toggles 1,0,0,1,1,0,1 -> no beat lost or duplicated; TDATA stable while stalled; 4 master transfers total.
- S1 first beat with TDATA[55:52]=4'h5 -> ftype_err=1 for exactly one cycle, packet forwarded intact. FTYPE=4'h6 -> no pulse.
- S0 sends a 1-beat packet while S1 is mid-packet (granted) -> S0_TREADY stays 0 until S1's TLAST is accepted and the IDLE bubble passes.
- Assert AXIS_ARESET during beat 2 of a 4-beat packet -> next cycle M_AXIS_TVALID=0, both TREADY=0, ftype_err=0; a new packet afterwards is arbitrated normally.
